// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the command sequencer: frame command codes,
// ALU operand register addresses and the sequencer state encoding.
package sys_ctrl_pkg;

  localparam int unsigned CMD_WIDTH = 8;

  localparam logic [CMD_WIDTH-1:0] CMD_WR      = 8'hAA;
  localparam logic [CMD_WIDTH-1:0] CMD_RD      = 8'hBB;
  localparam logic [CMD_WIDTH-1:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [CMD_WIDTH-1:0] CMD_ALU_NOP = 8'hDD;

  // Register-file slots holding the ALU operands
  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    ALU_A,
    ALU_B,
    ALU_FUN,
    ALU_WAIT,
    TX_LSB,
    TX_MSB
  } state_e;

endpackage

// File: rtl/sys_ctrl.sv
// Command sequencer: decodes RX frames into reg-file writes/reads and ALU
// operations, then pushes the result bytes into the TX FIFO.
// Ports:
//   clk, reset                       reference clock, synchronous active-high reset
//   rx_p_data, rx_d_vld              synchronized RX byte and its valid pulse
//   rd_data, rd_data_valid           reg-file read return
//   alu_out, alu_out_valid           ALU result return
//   fifo_full                        TX FIFO back-pressure
//   wr_en, rd_en, address, wr_data   reg-file access (registered)
//   alu_en, alu_fun, clk_gate_en     ALU control (registered)
//   tx_p_data, tx_d_vld              TX FIFO write (registered)
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned ALU_WIDTH  = 16,
  parameter int unsigned FUN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_p_data,
  input  logic                  rx_d_vld,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_data_valid,
  input  logic [ALU_WIDTH-1:0]  alu_out,
  input  logic                  alu_out_valid,
  input  logic                  fifo_full,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  alu_en,
  output logic [FUN_WIDTH-1:0]  alu_fun,
  output logic                  clk_gate_en,
  output logic [DATA_WIDTH-1:0] tx_p_data,
  output logic                  tx_d_vld
);

  state_e                state_q, state_nxt;
  logic [ALU_WIDTH-1:0]  result_q, result_nxt;
  logic                  is_alu_q, is_alu_nxt;   // result is two bytes wide

  logic                  wr_en_nxt, rd_en_nxt, alu_en_nxt, clk_gate_en_nxt, tx_d_vld_nxt;
  logic [ADDR_WIDTH-1:0] address_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt, tx_p_data_nxt;
  logic [FUN_WIDTH-1:0]  alu_fun_nxt;

  // Next-state and next-output decode
  always_comb begin
    state_nxt       = state_q;
    result_nxt      = result_q;
    is_alu_nxt      = is_alu_q;
    wr_en_nxt       = 1'b0;
    rd_en_nxt       = 1'b0;
    tx_d_vld_nxt    = 1'b0;
    alu_en_nxt      = alu_en;
    clk_gate_en_nxt = clk_gate_en;
    address_nxt     = address;
    wr_data_nxt     = wr_data;
    tx_p_data_nxt   = tx_p_data;
    alu_fun_nxt     = alu_fun;

    case (state_q)
      IDLE: begin
        if (rx_d_vld) begin
          if (rx_p_data == DATA_WIDTH'(CMD_WR))           state_nxt = WR_ADDR;
          else if (rx_p_data == DATA_WIDTH'(CMD_RD))      state_nxt = RD_ADDR;
          else if (rx_p_data == DATA_WIDTH'(CMD_ALU_OP))  state_nxt = ALU_A;
          else if (rx_p_data == DATA_WIDTH'(CMD_ALU_NOP)) state_nxt = ALU_FUN;
        end
      end
      WR_ADDR: begin
        if (rx_d_vld) begin
          address_nxt = rx_p_data[ADDR_WIDTH-1:0];
          state_nxt   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (rx_d_vld) begin
          wr_data_nxt = rx_p_data;
          wr_en_nxt   = 1'b1;
          state_nxt   = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_d_vld) begin
          address_nxt = rx_p_data[ADDR_WIDTH-1:0];
          rd_en_nxt   = 1'b1;
          state_nxt   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_data_valid) begin
          result_nxt = ALU_WIDTH'(rd_data);
          is_alu_nxt = 1'b0;
          state_nxt  = TX_LSB;
        end
      end
      ALU_A: begin
        if (rx_d_vld) begin
          address_nxt = ADDR_WIDTH'(OPA_ADDR);
          wr_data_nxt = rx_p_data;
          wr_en_nxt   = 1'b1;
          state_nxt   = ALU_B;
        end
      end
      ALU_B: begin
        if (rx_d_vld) begin
          address_nxt = ADDR_WIDTH'(OPB_ADDR);
          wr_data_nxt = rx_p_data;
          wr_en_nxt   = 1'b1;
          state_nxt   = ALU_FUN;
        end
      end
      ALU_FUN: begin
        if (rx_d_vld) begin
          alu_fun_nxt     = rx_p_data[FUN_WIDTH-1:0];
          alu_en_nxt      = 1'b1;
          clk_gate_en_nxt = 1'b1;
          state_nxt       = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (alu_out_valid) begin
          result_nxt = alu_out;
          is_alu_nxt = 1'b1;
          alu_en_nxt = 1'b0;
          state_nxt  = TX_LSB;
        end
      end
      TX_LSB: begin
        if (!fifo_full) begin
          tx_p_data_nxt = result_q[DATA_WIDTH-1:0];
          tx_d_vld_nxt  = 1'b1;
          state_nxt     = is_alu_q ? TX_MSB : IDLE;
        end
      end
      TX_MSB: begin
        if (!fifo_full) begin
          tx_p_data_nxt   = DATA_WIDTH'(result_q[ALU_WIDTH-1:DATA_WIDTH]);
          tx_d_vld_nxt    = 1'b1;
          clk_gate_en_nxt = 1'b0;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, holding registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      is_alu_q    <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      address     <= '0;
      wr_data     <= '0;
      alu_en      <= 1'b0;
      alu_fun     <= '0;
      clk_gate_en <= 1'b0;
      tx_p_data   <= '0;
      tx_d_vld    <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      result_q    <= result_nxt;
      is_alu_q    <= is_alu_nxt;
      wr_en       <= wr_en_nxt;
      rd_en       <= rd_en_nxt;
      address     <= address_nxt;
      wr_data     <= wr_data_nxt;
      alu_en      <= alu_en_nxt;
      alu_fun     <= alu_fun_nxt;
      clk_gate_en <= clk_gate_en_nxt;
      tx_p_data   <= tx_p_data_nxt;
      tx_d_vld    <= tx_d_vld_nxt;
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Scoreboard bench for sys_ctrl: expected reg-file writes, reads, ALU function
// codes and TX bytes are queued as frames are sent and checked as they appear.
module tb_sys_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_p_data;
  logic        rx_d_vld;
  logic [7:0]  rd_data;
  logic        rd_data_valid;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic        fifo_full;
  logic        wr_en, rd_en, alu_en, clk_gate_en, tx_d_vld;
  logic [3:0]  address;
  logic [7:0]  wr_data, tx_p_data;
  logic [3:0]  alu_fun;

  sys_ctrl dut (
    .clk(clk), .reset(reset),
    .rx_p_data(rx_p_data), .rx_d_vld(rx_d_vld),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .fifo_full(fifo_full),
    .wr_en(wr_en), .rd_en(rd_en), .address(address), .wr_data(wr_data),
    .alu_en(alu_en), .alu_fun(alu_fun), .clk_gate_en(clk_gate_en),
    .tx_p_data(tx_p_data), .tx_d_vld(tx_d_vld)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] wr_q[$];   // {addr, data}
  logic [3:0]  rd_q[$];
  logic [3:0]  alu_q[$];
  logic [7:0]  tx_q[$];

  logic [7:0]  model_reg[16];  // bench's own view of the register file
  logic [7:0]  env_reg[16];    // register file emulated around the DUT
  logic        full_mode = 1'b0;
  logic        fifo_full_at_edge = 1'b0;
  logic        alu_en_d = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] fun);
    case (fun)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return (b != 8'd0) ? 16'(a / b) : 16'd0;
      default: return 16'd0;
    endcase
  endfunction

  always @(posedge clk) fifo_full_at_edge <= fifo_full;

  // Output monitor against the scoreboard queues
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        if (wr_q.size() == 0) check("wr_unexpected", 16'd1, 16'd0);
        else begin
          logic [11:0] e;
          e = wr_q.pop_front();
          check("wr_addr", 16'(address), 16'(e[11:8]));
          check("wr_data", 16'(wr_data), 16'(e[7:0]));
        end
        env_reg[address] = wr_data;
      end
      if (rd_en) begin
        if (rd_q.size() == 0) check("rd_unexpected", 16'd1, 16'd0);
        else check("rd_addr", 16'(address), 16'(rd_q.pop_front()));
      end
      if (alu_en && !alu_en_d) begin
        if (alu_q.size() == 0) check("alu_unexpected", 16'd1, 16'd0);
        else check("alu_fun", 16'(alu_fun), 16'(alu_q.pop_front()));
        check("gate_on", 16'(clk_gate_en), 16'd1);
      end
      if (tx_d_vld) begin
        check("tx_while_full", 16'(fifo_full_at_edge), 16'd0);
        if (tx_q.size() == 0) check("tx_unexpected", 16'd1, 16'd0);
        else check("tx_byte", 16'(tx_p_data), 16'(tx_q.pop_front()));
      end
    end
    alu_en_d = alu_en;
  end

  // Register-file read responder: data returned two cycles after rd_en
  initial begin
    forever begin
      @(negedge clk);
      if (rd_en && !reset) begin
        logic [3:0] a;
        a = address;
        repeat (2) @(negedge clk);
        rd_data = env_reg[a];
        rd_data_valid = 1'b1;
        @(negedge clk);
        rd_data_valid = 1'b0;
        rd_data = 8'($urandom);
      end
    end
  end

  // ALU responder, optionally holding the TX FIFO full for five cycles
  initial begin
    forever begin
      @(negedge clk);
      if (alu_en && !reset) begin
        repeat (3) @(negedge clk);
        check("alu_en_held", 16'(alu_en), 16'd1);
        alu_out = alu_ref(env_reg[0], env_reg[1], alu_fun);
        alu_out_valid = 1'b1;
        if (full_mode) fifo_full = 1'b1;
        @(negedge clk);
        alu_out_valid = 1'b0;
        check("alu_en_drop", 16'(alu_en), 16'd0);
        if (full_mode) begin
          for (int i = 0; i < 5; i++) begin
            check("tx_held_full", 16'(tx_d_vld), 16'd0);
            if (i < 4) @(negedge clk);
          end
          fifo_full = 1'b0;
          full_mode = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_p_data = b;
    rx_d_vld  = 1'b1;
    @(negedge clk);
    rx_d_vld  = 1'b0;
    rx_p_data = 8'($urandom);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size()) != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      check({tag, "_timeout"}, 16'd1, 16'd0);
      wr_q.delete(); rd_q.delete(); alu_q.delete(); tx_q.delete();
    end
    repeat (3) @(negedge clk);
    check({tag, "_gate_off"}, 16'(clk_gate_en), 16'd0);
  endtask

  task automatic frame_wr(input logic [3:0] a, input logic [7:0] d);
    model_reg[a] = d;
    wr_q.push_back({a, d});
    send_byte(8'hAA); send_byte(8'(a)); send_byte(d);
  endtask

  task automatic frame_rd(input logic [3:0] a);
    rd_q.push_back(a);
    tx_q.push_back(model_reg[a]);
    send_byte(8'hBB); send_byte(8'(a));
  endtask

  task automatic frame_alu_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    logic [15:0] r;
    model_reg[0] = a;
    model_reg[1] = b;
    r = alu_ref(a, b, f);
    wr_q.push_back({4'd0, a});
    wr_q.push_back({4'd1, b});
    alu_q.push_back(f);
    tx_q.push_back(r[7:0]);
    tx_q.push_back(r[15:8]);
    send_byte(8'hCC); send_byte(a); send_byte(b); send_byte(8'(f));
  endtask

  task automatic frame_alu_nop(input logic [3:0] f);
    logic [15:0] r;
    r = alu_ref(model_reg[0], model_reg[1], f);
    alu_q.push_back(f);
    tx_q.push_back(r[7:0]);
    tx_q.push_back(r[15:8]);
    send_byte(8'hDD); send_byte(8'(f));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_wr_en"},    16'(wr_en), 16'd0);
    check({tag, "_rd_en"},    16'(rd_en), 16'd0);
    check({tag, "_address"},  16'(address), 16'd0);
    check({tag, "_wr_data"},  16'(wr_data), 16'd0);
    check({tag, "_alu_en"},   16'(alu_en), 16'd0);
    check({tag, "_alu_fun"},  16'(alu_fun), 16'd0);
    check({tag, "_gate"},     16'(clk_gate_en), 16'd0);
    check({tag, "_tx_data"},  16'(tx_p_data), 16'd0);
    check({tag, "_tx_vld"},   16'(tx_d_vld), 16'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      model_reg[i] = 8'h00;
      env_reg[i]   = 8'h00;
    end
    reset = 1'b1;
    rx_p_data = 8'h00; rx_d_vld = 1'b0;
    rd_data = 8'h00; rd_data_valid = 1'b0;
    alu_out = 16'h0000; alu_out_valid = 1'b0;
    fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;
    @(negedge clk);

    // Basic write, read, ALU with operands, ALU on stored operands under back-pressure
    frame_wr(4'h5, 8'h3C);            drain("wr5");
    frame_rd(4'h5);                   drain("rd5");
    frame_alu_op(8'h0A, 8'h03, 4'h0); drain("aluop");
    full_mode = 1'b1;
    frame_alu_nop(4'h2);              drain("alunop_full");

    // Unknown command byte ignored in IDLE
    send_byte(8'h55);
    frame_wr(4'h1, 8'hFF);            drain("ign55");
    frame_rd(4'h1);                   drain("rd1");

    // Reset mid-frame discards the partial write
    frame_wr(4'h7, 8'h5A);            drain("wr7");
    send_byte(8'hAA); send_byte(8'h07);
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    check_reset_state("midrst");
    reset = 1'b0;
    @(negedge clk);
    frame_rd(4'h7);                   drain("rd7");

    // Randomized write/read and ALU frames
    for (int i = 0; i < 6; i++) begin
      logic [3:0] a;
      a = 4'($urandom_range(2, 15));
      frame_wr(a, 8'($urandom));
      frame_rd(a);
      drain("rand_wr_rd");
    end
    for (int i = 0; i < 4; i++) begin
      frame_alu_op(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
                   4'($urandom_range(0, 3)));
      drain("rand_alu");
    end

    check("end_wr_q", 16'(wr_q.size()), 16'd0);
    check("end_tx_q", 16'(tx_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
